// File: rtl/dispatch_pkg.sv
// Shared definitions for the demux dispatcher: FSM state encoding, mode
// constants and the select-width helper.
package dispatch_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_e;

   localparam logic MODE_DIRECTED = 1'b0;
   localparam logic MODE_RR       = 1'b1;

   // Select width for a given consumer count; never narrower than one bit.
   function automatic int unsigned sel_width(input int unsigned num_out);
      if (num_out <= 2) begin
         return 1;
      end
      return $clog2(num_out);
   endfunction

endpackage

// File: rtl/dispatch_rr_pointer.sv
// Round-robin destination pointer: wrapping counter over 0..NUM_OUT-1 that
// moves by one whenever advance is high. Synchronous active-high reset.
module dispatch_rr_pointer
   import dispatch_pkg::*;
#(
   parameter int unsigned NUM_OUT   = 2,
   parameter int unsigned SEL_WIDTH = 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 advance,
   output logic [SEL_WIDTH-1:0] ptr
);

   logic [SEL_WIDTH-1:0] ptr_q, ptr_d;

   // Next pointer: wrap explicitly at the last consumer.
   always_comb begin
      ptr_d = ptr_q;
      if (advance) begin
         if (ptr_q == SEL_WIDTH'(NUM_OUT - 1)) begin
            ptr_d = '0;
         end else begin
            ptr_d = ptr_q + SEL_WIDTH'(1);
         end
      end
   end

   // Pointer register.
   always_ff @(posedge clock) begin
      if (reset) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr = ptr_q;

endmodule

// File: rtl/demux_dispatcher.sv
// Demux dispatcher: accepts one producer stream (valid/ready), holds each word
// in a one-entry register and presents it to one of NUM_OUT consumers via the
// demux select and one-hot valids. Destination is either producer-directed or
// taken from an internal round-robin pointer, sampled at accept.
// Optional feature: DISPATCH_STALL_TIMEOUT_EN adds a stall counter that drops
// a held word after TIMEOUT_CYCLES stalled SEND cycles and pulses 'dropped'.
module demux_dispatcher
   import dispatch_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned NUM_OUT        = 2,
   // Derived from NUM_OUT; do not override.
   parameter int unsigned SEL_WIDTH      = sel_width(NUM_OUT),
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [SEL_WIDTH-1:0]  in_dest,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  mode,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [NUM_OUT-1:0]    out_valid,
   input  logic [NUM_OUT-1:0]    out_ready,
   output logic [SEL_WIDTH-1:0]  sel,
   output logic                  busy
`ifdef DISPATCH_STALL_TIMEOUT_EN
   ,
   output logic                  dropped
`endif
);

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [SEL_WIDTH-1:0]  sel_q, sel_d;
   logic [SEL_WIDTH-1:0]  rr_ptr;

   logic accept;
   logic transfer;
   logic drop;

   // Only the selected consumer's ready matters; others are ignored.
   assign transfer = (state_q == ST_SEND) & out_ready[sel_q];
   // Combinational from out_ready so a word can leave and enter in one cycle.
   assign in_ready = enable & ((state_q == ST_IDLE) | out_ready[sel_q]) & ~drop;
   assign accept   = in_valid & in_ready;

   dispatch_rr_pointer #(
      .NUM_OUT   (NUM_OUT),
      .SEL_WIDTH (SEL_WIDTH)
   ) u_rr_pointer (
      .clock   (clock),
      .reset   (reset),
      .advance (accept & (mode == MODE_RR)),
      .ptr     (rr_ptr)
   );

`ifdef DISPATCH_STALL_TIMEOUT_EN
   localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_WIDTH-1:0] stall_q, stall_d;

   // Drop on the cycle that would be the TIMEOUT_CYCLES-th stalled SEND cycle.
   assign drop    = (state_q == ST_SEND) & ~transfer &
                    (stall_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
   assign dropped = drop;

   // Count consecutive stalled SEND cycles; any transfer, accept or drop clears.
   always_comb begin
      stall_d = '0;
      if ((state_q == ST_SEND) && !transfer && !drop) begin
         stall_d = stall_q + CNT_WIDTH'(1);
      end
   end

   // Stall counter register.
   always_ff @(posedge clock) begin
      if (reset) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end
`else
   logic unused_timeout;

   assign drop           = 1'b0;
   assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

   // Next state: accept wins (loads a new word even while one leaves),
   // otherwise a transfer or a drop empties the holding register.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      sel_d   = sel_q;
      if (accept) begin
         state_d = ST_SEND;
         data_d  = in_data;
         sel_d   = (mode == MODE_RR) ? rr_ptr : in_dest;
      end else if (transfer || drop) begin
         state_d = ST_IDLE;
      end
   end

   // State, held word and select registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         data_q  <= '0;
         sel_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         sel_q   <= sel_d;
      end
   end

   // Present the held word; bus and valids are gated to zero when idle.
   always_comb begin
      out_valid = '0;
      out_data  = '0;
      busy      = 1'b0;
      if (state_q == ST_SEND) begin
         out_valid[sel_q] = 1'b1;
         out_data         = data_q;
         busy             = 1'b1;
      end
   end

   assign sel = sel_q;

endmodule
